pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID and later stages) with a
//  valid/ready handshake and a 2-entry skid buffer.
//  Supports back-pressure without a combinational ready path, and a flush that
//  inserts a NOP bubble.
//  Sits between a producer stage and a consumer stage; throughput is 1 word/cycle.
// PARAMETERS
//  INST_W    32            width of instruction field
//  PC_W      32            width of PC+4 field
//  NOP_INST  32'h0000_0000 value driven on out_inst when no valid word is held
//  CNT_W     16            width of perf counters (PIPE_STAGE_PERF_EN only)
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  in_valid    in   1       producer word valid
//  in_ready    out  1       stage can accept a word this cycle
//  in_inst     in   INST_W  producer instruction
//  in_pc4      in   PC_W    producer PC+4
//  flush       in   1       discard all held words and insert a bubble
//  out_valid   out  1       out_inst/out_pc4 valid
//  out_ready   in   1       consumer accepts a word this cycle
//  out_inst    out  INST_W  held instruction (NOP_INST when out_valid=0)
//  out_pc4     out  PC_W    held PC+4
//  occupancy   out  2       words held: 0, 1 or 2
//  stall_cnt   out  CNT_W   cycles with out_valid & !out_ready
//  bubble_cnt  out  CNT_W   cycles with out_valid=0
// BEHAVIOUR
//  Storage and handshake
//  - Storage is a main register (drives out_*) and a skid register.
//  - State is EMPTY/ONE/FULL, encoded 0/1/2 and driven directly on occupancy.
//  - acc = in_valid & in_ready; con = out_valid & out_ready.
//  - in_ready = (state != FULL) and out_valid = (state != EMPTY).
//    Both are decoded from flops only; no in->out combinational path.
//  Reset (async assert, sync release)
//  - state=EMPTY, out_inst=NOP_INST, out_pc4=0, skid contents=0.
//  - Hence in_ready=1 and out_valid=0 during and after reset.
//  State transitions (no flush)
//  - EMPTY: acc -> ONE, main<=in.
//  - ONE: acc&con -> ONE, main<=in.
//  - ONE: acc&!con -> FULL, skid<=in.
//  - ONE: !acc&con -> EMPTY, main<=NOP_INST, pc4 held.
//  - FULL: con -> ONE, main<=skid. acc is impossible (in_ready=0).
//  - No acc and no con: state and data hold. Words leave in arrival order.
//  Latency and throughput
//  - Latency: word accepted in cycle N appears on out_* in cycle N+1 (EMPTY/ONE).
//  - Back-to-back throughput is 1/cycle while out_ready=1.
//  Flush (synchronous, highest priority)
//  - Next state is EMPTY and out_inst<=NOP_INST; out_pc4 holds.
//  - A word offered in the flush cycle is dropped, even if in_ready=1.
//  - A con in the flush cycle still counts as consumed by the downstream stage.
//  Invariants
//  - out_inst equals NOP_INST whenever out_valid=0.
//  - Reset asserted mid-transfer discards both entries immediately.
// CONFIGURATION
//  - PIPE_STAGE_PERF_EN defined:
//    - stall_cnt increments on each cycle with out_valid & !out_ready.
//    - bubble_cnt increments on each cycle with out_valid=0.
//    - Both saturate at 2^CNT_W-1, are cleared only by reset, and are not
//      affected by flush.
//  - Not defined: no counter logic is built; stall_cnt and bubble_cnt are
//    tied to 0. All other behaviour is identical.
// TESTING
//  - Reset: reset=0 mid-stream -> out_valid=0, out_inst=NOP_INST, in_ready=1,
//    occupancy=0 asynchronously.
//  - Streaming: out_ready=1, in_inst=1,2,3 on cycles 0-2 -> out_inst=1,2,3
//    on cycles 1-3, occupancy=1.
//  - Back-pressure: out_ready=0, push A,B -> occupancy=2, in_ready=0,
//    C held at input. Then out_ready=1 -> A, B, C delivered in order.
//  - Flush: occupancy=2 plus flush=1 with in_valid=1 ->
//    next cycle occupancy=0, out_inst=NOP_INST, offered word dropped.
//  - Simultaneous events: state ONE with acc&con every cycle for 8 cycles ->
//    occupancy stays 1 and data updates each cycle.
//  - Perf (macro on, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles ->
//    stall_cnt=15 (saturated). Macro off -> both counters read 0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc4,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [PC_W-1:0]   main_pc4_q, main_pc4_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]   skid_pc4_q, skid_pc4_d;
    logic              acc, con;

    // Handshake flags come straight from the state flop, so ready never depends on inputs.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;
    assign con       = out_valid & out_ready;

    assign out_inst  = main_inst_q;
    assign out_pc4   = main_pc4_q;
    assign occupancy = state_q;

    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc4_d  = main_pc4_q;
        skid_inst_d = skid_inst_q;
        skid_pc4_d  = skid_pc4_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_inst_d = NOP_INST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d     = ST_ONE;
                        main_inst_d = in_inst;
                        main_pc4_d  = in_pc4;
                    end
                end
                ST_ONE: begin
                    if (acc && con) begin
                        main_inst_d = in_inst;
                        main_pc4_d  = in_pc4;
                    end else if (acc) begin
                        state_d     = ST_FULL;
                        skid_inst_d = in_inst;
                        skid_pc4_d  = in_pc4;
                    end else if (con) begin
                        state_d     = ST_EMPTY;
                        main_inst_d = NOP_INST;
                    end
                end
                ST_FULL: begin
                    if (con) begin
                        state_d     = ST_ONE;
                        main_inst_d = skid_inst_q;
                        main_pc4_d  = skid_pc4_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_inst_d = NOP_INST;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= NOP_INST;
            main_pc4_q  <= '0;
            skid_inst_q <= '0;
            skid_pc4_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_pc4_q  <= main_pc4_d;
            skid_inst_q <= skid_inst_d;
            skid_pc4_q  <= skid_pc4_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush does not touch them, only reset clears them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_pipe_stage_skid;

    localparam int          CNT_W   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_inst = '0;
    logic [31:0]      in_pc4 = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc4;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_skid #(
        .INST_W   (32),
        .PC_W     (32),
        .NOP_INST (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc4     (in_pc4),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc4    (out_pc4),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } word_t;

    // Reference model: an ordered list of held words plus the last visible PC+4.
    word_t       mq[$];
    logic [31:0] held_pc4;
    int          m_stall;
    int          m_bubble;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        held_pc4 = '0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic model_step();
        int    sz;
        bit    acc;
        bit    con;
        word_t w;
        sz  = mq.size();
        acc = in_valid && (sz < 2);
        con = (sz > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
        if (sz > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
        if (sz == 0 && m_bubble < CNT_MAX) m_bubble++;
`endif
        if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) begin
                w.inst = in_inst;
                w.pc4  = in_pc4;
                mq.push_back(w);
            end
        end
        if (mq.size() > 0) held_pc4 = mq[0].pc4;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] exp_inst;
        exp_inst = (mq.size() > 0) ? mq[0].inst : NOP;
        check_eq({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
        check_eq({tag, " occupancy"}, 64'(occupancy), 64'(mq.size()));
        check_eq({tag, " out_inst"}, 64'(out_inst), 64'(exp_inst));
        check_eq({tag, " out_pc4"}, 64'(out_pc4), 64'(held_pc4));
        check_eq({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        check_eq({tag, " bubble_cnt"}, 64'(bubble_cnt), 64'(m_bubble));
    endtask

    // Drive inputs away from the edge, advance one cycle, then compare on the falling edge.
    task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [31:0] pc4,
                                 input bit fl, input bit ordy, input string tag);
        in_valid  = v;
        in_inst   = inst;
        in_pc4    = pc4;
        flush     = fl;
        out_ready = ordy;
        @(posedge clock);
        if (reset) model_step();
        @(negedge clock);
        checkOutput(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        checkOutput("reset");
        reset = 1'b1;

        // Streaming: one word per cycle, one-cycle latency
        applyStimulus(1, 32'd1, 32'h104, 0, 1, "stream1");
        check_eq("stream1 direct", 64'(out_inst), 64'd1);
        applyStimulus(1, 32'd2, 32'h108, 0, 1, "stream2");
        check_eq("stream2 direct", 64'(out_inst), 64'd2);
        applyStimulus(1, 32'd3, 32'h10c, 0, 1, "stream3");
        check_eq("stream3 direct", 64'(out_inst), 64'd3);
        check_eq("stream3 occ", 64'(occupancy), 64'd1);
        applyStimulus(0, 32'd0, 32'd0, 0, 1, "drain");
        check_eq("drain nop", 64'(out_inst), 64'(NOP));

        // Back-pressure: A,B fill both entries, C waits, then in-order delivery
        applyStimulus(1, 32'hA, 32'h200, 0, 0, "bp_a");
        applyStimulus(1, 32'hB, 32'h204, 0, 0, "bp_b");
        check_eq("bp full occ", 64'(occupancy), 64'd2);
        check_eq("bp full in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1, 32'hC, 32'h208, 0, 0, "bp_c_wait");
        check_eq("bp head A", 64'(out_inst), 64'hA);
        applyStimulus(1, 32'hC, 32'h208, 0, 1, "bp_rel1");
        check_eq("bp head B", 64'(out_inst), 64'hB);
        applyStimulus(1, 32'hC, 32'h208, 0, 1, "bp_rel2");
        check_eq("bp head C", 64'(out_inst), 64'hC);
        applyStimulus(0, 32'd0, 32'd0, 0, 1, "bp_drain");

        // Flush while full, with a word offered that must be dropped
        applyStimulus(1, 32'h11, 32'h300, 0, 0, "fl_a");
        applyStimulus(1, 32'h22, 32'h304, 0, 0, "fl_b");
        applyStimulus(1, 32'h33, 32'h308, 1, 0, "flush");
        check_eq("flush occ", 64'(occupancy), 64'd0);
        check_eq("flush nop", 64'(out_inst), 64'(NOP));
        check_eq("flush pc4 held", 64'(out_pc4), 64'h300);
        applyStimulus(0, 32'd0, 32'd0, 0, 1, "flush_after");
        check_eq("flush dropped", 64'(out_valid), 64'd0);

        // Simultaneous accept and consume for 8 cycles
        applyStimulus(1, 32'h100, 32'h400, 0, 1, "sim_fill");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1, 32'h100 + 32'(i), 32'h400 + 32'(4 * i), 0, 1, "sim");
            check_eq("sim occ", 64'(occupancy), 64'd1);
            check_eq("sim data", 64'(out_inst), 64'(32'h100 + 32'(i)));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom,
                          $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, "rand");
        end

        // Asynchronous reset in the middle of a transfer
        applyStimulus(1, 32'h55, 32'h500, 0, 0, "ar_a");
        applyStimulus(1, 32'h66, 32'h504, 0, 0, "ar_b");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checkOutput("async_reset");
        @(negedge clock);
        reset = 1'b1;

        // Stall counter saturation (or tie-off check when counters are absent)
        applyStimulus(1, 32'h77, 32'h600, 0, 0, "perf_fill");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 32'd0, 32'd0, 0, 0, "perf");
        end
`ifdef PIPE_STAGE_PERF_EN
        check_eq("perf stall sat", 64'(stall_cnt), 64'(CNT_MAX));
`else
        check_eq("perf stall tied", 64'(stall_cnt), 64'd0);
        check_eq("perf bubble tied", 64'(bubble_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
